// File: rtl/pipe_stage.sv
// pipe_stage: generic inter-stage pipeline register with a valid/ready
// handshake, a 2-entry skid buffer and a synchronous flush. The control
// bundle is masked to zero whenever the output holds no valid beat, so a
// downstream stage sees a NOP on bubbles.
module pipe_stage #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [CTRL_W-1:0] out_ctrl_o,
  input  logic              flush_i,
  output logic [1:0]        count_o
);

  // The state encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t              state_reg, state_next;
  logic [DATA_W-1:0]   main_data_reg, main_data_next;
  logic [CTRL_W-1:0]   main_ctrl_reg, main_ctrl_next;
  logic [DATA_W-1:0]   skid_data_reg, skid_data_next;
  logic [CTRL_W-1:0]   skid_ctrl_reg, skid_ctrl_next;

  logic accept;
  logic drain;

  // Handshake-facing status comes straight from the state register, so
  // in_ready_o never depends combinationally on out_ready_i.
  assign in_ready_o  = (state_reg != ST_TWO);
  assign out_valid_o = (state_reg != ST_EMPTY);
  assign count_o     = state_reg;
  assign out_data_o  = main_data_reg;

  assign accept = in_valid_i & in_ready_o;
  assign drain  = out_valid_o & out_ready_i;

  // Per-bit NOP masking of the control bundle on bubbles.
  generate
    for (genvar gi = 0; gi < CTRL_W; gi++) begin : g_ctrl_mask
      assign out_ctrl_o[gi] = main_ctrl_reg[gi] & out_valid_o;
    end
  endgenerate

  // State and storage registers; reset clears everything immediately.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg     <= ST_EMPTY;
      main_data_reg <= '0;
      main_ctrl_reg <= '0;
      skid_data_reg <= '0;
      skid_ctrl_reg <= '0;
    end else begin
      state_reg     <= state_next;
      main_data_reg <= main_data_next;
      main_ctrl_reg <= main_ctrl_next;
      skid_data_reg <= skid_data_next;
      skid_ctrl_reg <= skid_ctrl_next;
    end
  end

  // Next-state and storage update; flush only empties the state and leaves
  // the data registers untouched (a beat accepted alongside it is dropped).
  always_comb begin
    state_next     = state_reg;
    main_data_next = main_data_reg;
    main_ctrl_next = main_ctrl_reg;
    skid_data_next = skid_data_reg;
    skid_ctrl_next = skid_ctrl_reg;

    if (flush_i) begin
      state_next = ST_EMPTY;
    end else begin
      case (state_reg)
        ST_EMPTY: begin
          if (accept) begin
            main_data_next = in_data_i;
            main_ctrl_next = in_ctrl_i;
            state_next     = ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && drain) begin
            main_data_next = in_data_i;
            main_ctrl_next = in_ctrl_i;
          end else if (accept) begin
            skid_data_next = in_data_i;
            skid_ctrl_next = in_ctrl_i;
            state_next     = ST_TWO;
          end else if (drain) begin
            state_next = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (drain) begin
            main_data_next = skid_data_reg;
            main_ctrl_next = skid_ctrl_reg;
            state_next     = ST_ONE;
          end
        end
        default: begin
          state_next = ST_EMPTY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_stage.sv
// tb_pipe_stage: directed scenarios plus randomized traffic for pipe_stage,
// checked every cycle against a queue-based reference of the stage.
module tb_pipe_stage;

  localparam int DATA_W = 32;
  localparam int CTRL_W = 4;

  logic              clk_i;
  logic              rst_i;
  logic              in_valid_i;
  logic              in_ready_o;
  logic [DATA_W-1:0] in_data_i;
  logic [CTRL_W-1:0] in_ctrl_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [DATA_W-1:0] out_data_o;
  logic [CTRL_W-1:0] out_ctrl_o;
  logic              flush_i;
  logic [1:0]        count_o;

  pipe_stage #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_data_i),
    .in_ctrl_i   (in_ctrl_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .out_ctrl_o  (out_ctrl_o),
    .flush_i     (flush_i),
    .count_o     (count_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // Reference: a FIFO of at most two beats plus the last head payload.
  typedef struct {
    logic [DATA_W-1:0] d;
    logic [CTRL_W-1:0] c;
  } beat_t;

  beat_t             model_q[$];
  logic [DATA_W-1:0] last_d;
  int                n_cmp;
  int                n_err;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    model_q.delete();
    last_d = '0;
  endtask

  task automatic check_model();
    logic [DATA_W-1:0] exp_d;
    logic [CTRL_W-1:0] exp_c;
    exp_d = (model_q.size() != 0) ? model_q[0].d : last_d;
    exp_c = (model_q.size() != 0) ? model_q[0].c : '0;
    chk("out_valid", 64'(out_valid_o), 64'(model_q.size() != 0));
    chk("in_ready",  64'(in_ready_o),  64'(model_q.size() < 2));
    chk("count",     64'(count_o),     64'(model_q.size()));
    chk("out_data",  64'(out_data_o),  64'(exp_d));
    chk("out_ctrl",  64'(out_ctrl_o),  64'(exp_c));
  endtask

  // One clock of traffic: drive, advance the reference at the edge, check.
  task automatic step(input logic v, input logic [DATA_W-1:0] d,
                      input logic [CTRL_W-1:0] c, input logic r, input logic f);
    logic  acc;
    logic  drn;
    beat_t b;
    in_valid_i  = v;
    in_data_i   = d;
    in_ctrl_i   = c;
    out_ready_i = r;
    flush_i     = f;
    @(posedge clk_i);
    acc = v && (model_q.size() < 2);
    drn = r && (model_q.size() != 0);
    if (f) begin
      model_q.delete();
    end else begin
      if (drn) void'(model_q.pop_front());
      if (acc) begin
        b.d = d;
        b.c = c;
        model_q.push_back(b);
      end
    end
    if (model_q.size() != 0) last_d = model_q[0].d;
    @(negedge clk_i);
    $display("t=%0t v=%0b d=%h c=%h rdy=%0b fl=%0b acc=%0b drn=%0b cnt=%0d out=%h/%h",
             $time, v, d, c, r, f, acc, drn, count_o, out_data_o, out_ctrl_o);
    check_model();
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_valid"}, 64'(out_valid_o), 64'd0);
    chk({tag, "_ctrl"},  64'(out_ctrl_o),  64'd0);
    chk({tag, "_data"},  64'(out_data_o),  64'd0);
    chk({tag, "_count"}, 64'(count_o),     64'd0);
    chk({tag, "_ready"}, 64'(in_ready_o),  64'd1);
  endtask

  initial begin
    n_cmp       = 0;
    n_err       = 0;
    rst_i       = 1'b0;
    in_valid_i  = 1'b0;
    in_data_i   = '0;
    in_ctrl_i   = '0;
    out_ready_i = 1'b0;
    flush_i     = 1'b0;
    model_reset();

    // Asynchronous reset before any clock edge.
    #2 rst_i = 1'b1;
    #1 check_reset_vals("rst");
    @(negedge clk_i);
    rst_i = 1'b0;

    // Streaming at full rate.
    step(1'b1, 32'h11, 4'h1, 1'b1, 1'b0);
    chk("str_d0", 64'(out_data_o), 64'h11);
    step(1'b1, 32'h22, 4'h2, 1'b1, 1'b0);
    chk("str_d1", 64'(out_data_o), 64'h22);
    chk("str_cnt", 64'(count_o), 64'd1);
    step(1'b1, 32'h33, 4'h3, 1'b1, 1'b0);
    chk("str_d2", 64'(out_data_o), 64'h33);
    step(1'b0, 32'h0, 4'h0, 1'b1, 1'b0);

    // Backpressure: A, B fill the stage, C is refused until it drains.
    step(1'b1, 32'hA, 4'h5, 1'b0, 1'b0);
    step(1'b1, 32'hB, 4'h6, 1'b0, 1'b0);
    step(1'b1, 32'hC, 4'h7, 1'b0, 1'b0);
    chk("bp_cnt", 64'(count_o), 64'd2);
    chk("bp_rdy", 64'(in_ready_o), 64'd0);
    chk("bp_head", 64'(out_data_o), 64'hA);
    step(1'b1, 32'hC, 4'h7, 1'b1, 1'b0);
    chk("bp_b", 64'(out_data_o), 64'hB);
    step(1'b1, 32'hC, 4'h7, 1'b1, 1'b0);
    chk("bp_c", 64'(out_data_o), 64'hC);
    step(1'b0, 32'h0, 4'h0, 1'b1, 1'b0);
    chk("bp_empty", 64'(count_o), 64'd0);

    // Flush from TWO, then from ONE with a simultaneous accept.
    step(1'b1, 32'hD1, 4'h9, 1'b0, 1'b0);
    step(1'b1, 32'hD2, 4'hA, 1'b0, 1'b0);
    step(1'b0, 32'h0, 4'h0, 1'b0, 1'b1);
    chk("fl2_cnt", 64'(count_o), 64'd0);
    chk("fl2_ctrl", 64'(out_ctrl_o), 64'd0);
    step(1'b1, 32'hE1, 4'hB, 1'b0, 1'b0);
    step(1'b1, 32'h77, 4'hC, 1'b0, 1'b1);
    chk("fl1_cnt", 64'(count_o), 64'd0);
    chk("fl1_valid", 64'(out_valid_o), 64'd0);
    step(1'b1, 32'h78, 4'hD, 1'b0, 1'b1);
    chk("fl0_cnt", 64'(count_o), 64'd0);

    // Bubble masking.
    step(1'b1, 32'h1234, 4'hF, 1'b0, 1'b0);
    chk("bub_ctrl", 64'(out_ctrl_o), 64'hF);
    step(1'b0, 32'h0, 4'h0, 1'b1, 1'b0);
    chk("bub_mask", 64'(out_ctrl_o), 64'h0);
    chk("bub_hold", 64'(out_data_o), 64'h1234);

    // Reset mid-operation in TWO, asserted between edges.
    step(1'b1, 32'hF1, 4'h3, 1'b0, 1'b0);
    step(1'b1, 32'hF2, 4'h4, 1'b0, 1'b0);
    #2 rst_i = 1'b1;
    #1 check_reset_vals("mid");
    model_reset();
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    step(1'b1, 32'h55, 4'h2, 1'b1, 1'b0);
    chk("post_rst", 64'(out_data_o), 64'h55);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, $urandom(), 4'($urandom_range(0, 15)),
           $urandom_range(0, 9) < 7, $urandom_range(0, 15) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
